// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types for operand forwarding (select codes, register index, destination tag)
package pipeline_pkg;
  typedef enum logic [1:0] {
    FWD_WB  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_RF  = 2'b10
  } fwd_sel_t;
  typedef logic [2:0] reg_idx_t;
  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    logic     is_load;
  } stage_tag_t;
  localparam stage_tag_t TAG_NONE = '0;
  function automatic logic tag_hit(logic used, reg_idx_t src, logic valid, reg_idx_t rd);
    return used & valid & (src == rd);
  endfunction
endpackage

// File: rtl/dest_tag_pipe.sv
// dest_tag_pipe: 3-slot destination tag shift pipe (EX, MEM, WB), advanced every cycle
// Ports: clk, rst (sync, active high); id_tag_i tag entering EX; ex_tag_o/mem_tag_o/wb_tag_o current slot contents
module dest_tag_pipe
  import pipeline_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  stage_tag_t id_tag_i,
  output stage_tag_t ex_tag_o,
  output stage_tag_t mem_tag_o,
  output stage_tag_t wb_tag_o
);
  stage_tag_t ex_q, mem_q, wb_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= TAG_NONE;
      mem_q <= TAG_NONE;
      wb_q  <= TAG_NONE;
    end else begin
      ex_q  <= id_tag_i;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end
  assign ex_tag_o  = ex_q;
  assign mem_tag_o = mem_q;
  assign wb_tag_o  = wb_q;
endmodule

// File: rtl/operand_forward_ctrl.sv
// operand_forward_ctrl: decode-stage hazard detection producing registered ALU operand selects and a load-use stall
// Ports: clk, rst (sync, active high); id_* decode-stage instruction fields; flush kills the decode instruction;
//        alu_src1_select/alu_src2_select registered selects for the instruction in EX; stall combinational.
// Config: OPERAND_FORWARDING_EN defined -> EX/MEM forwarding with load-use stall; undefined -> interlock only.
module operand_forward_ctrl
  import pipeline_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     id_valid,
  input  reg_idx_t id_rs1,
  input  reg_idx_t id_rs2,
  input  logic     id_rs1_used,
  input  logic     id_rs2_used,
  input  logic     id_alu_src_select,
  input  reg_idx_t id_rd,
  input  logic     id_reg_write,
  input  logic     id_mem_read,
  input  logic     flush,
  output fwd_sel_t alu_src1_select,
  output fwd_sel_t alu_src2_select,
  output logic     stall
);
  stage_tag_t id_tag, ex_tag, mem_tag, wb_tag;
  fwd_sel_t sel1_raw, sel2_raw, sel1_d, sel2_d, sel1_q, sel2_q;
  logic use1, use2, ex1, ex2, mem1, mem2, hazard;
  logic unused_bits;
  // Operand 2 from the shamt field never reads a register, so it cannot hazard.
  assign use1 = id_valid & id_rs1_used;
  assign use2 = id_valid & id_rs2_used & id_alu_src_select;
  assign ex1  = tag_hit(use1, id_rs1, ex_tag.valid, ex_tag.rd);
  assign ex2  = tag_hit(use2, id_rs2, ex_tag.valid, ex_tag.rd);
  assign mem1 = tag_hit(use1, id_rs1, mem_tag.valid, mem_tag.rd);
  assign mem2 = tag_hit(use2, id_rs2, mem_tag.valid, mem_tag.rd);
`ifdef OPERAND_FORWARDING_EN
  // Only a load still in EX has no data to forward yet; the EX match outranks MEM (younger producer).
  assign hazard   = (ex1 | ex2) & ex_tag.is_load;
  assign sel1_raw = ex1 ? FWD_MEM : (mem1 ? FWD_WB : FWD_RF);
  assign sel2_raw = ex2 ? FWD_MEM : (mem2 ? FWD_WB : FWD_RF);
`else
  assign hazard   = ex1 | ex2 | mem1 | mem2;
  assign sel1_raw = FWD_RF;
  assign sel2_raw = FWD_RF;
`endif
  // flush overrides stall: the killed instruction needs no hold.
  assign stall  = hazard & ~flush;
  assign sel1_d = (stall | flush) ? FWD_RF : sel1_raw;
  assign sel2_d = (stall | flush) ? FWD_RF : sel2_raw;
  assign id_tag = '{valid: id_valid & id_reg_write & ~stall & ~flush, rd: id_rd, is_load: id_mem_read};
  // WB needs no forwarding (write-before-read register file); MEM load flag is irrelevant.
  assign unused_bits = ^{wb_tag, mem_tag.is_load};
  dest_tag_pipe u_tags (
    .clk      (clk),
    .rst      (rst),
    .id_tag_i (id_tag),
    .ex_tag_o (ex_tag),
    .mem_tag_o(mem_tag),
    .wb_tag_o (wb_tag)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      sel1_q <= FWD_RF;
      sel2_q <= FWD_RF;
    end else begin
      sel1_q <= sel1_d;
      sel2_q <= sel2_d;
    end
  end
  assign alu_src1_select = sel1_q;
  assign alu_src2_select = sel2_q;
endmodule
